aes_axis_tx: RTL

//  Drains 128-bit result blocks from the output FIFO written by the AES controller.

---
 rtl/aes_axis_tx_pkg.sv | 26 ++
 rtl/aes_axis_tx_if.sv | 25 ++
 rtl/aes_axis_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aes_axis_tx_pkg.sv
// Shared widths, FSM state type and beat-select helper for the AES AXI-Stream transmitter.
package aes_axis_tx_pkg;

    localparam int FIFO_DATA_WIDTH      = 128;
    localparam int C_M_AXIS_TDATA_WIDTH = 32;
    localparam int BEATS                = FIFO_DATA_WIDTH / C_M_AXIS_TDATA_WIDTH;
    localparam int STRB_WIDTH           = C_M_AXIS_TDATA_WIDTH / 8;
    localparam int CNT_WIDTH            = 16;
    localparam int BEAT_CNT_WIDTH       = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_LAST   = 2'd3
    } tx_state_e;

    // Block is indexed [0:127]; beat k is the k-th 32-bit slice counting from bit 0.
    function automatic logic [C_M_AXIS_TDATA_WIDTH-1:0] blk_word(
        input logic [0:FIFO_DATA_WIDTH-1] blk,
        input logic [BEAT_CNT_WIDTH-1:0]  idx
    );
        return blk[int'(idx)*C_M_AXIS_TDATA_WIDTH +: C_M_AXIS_TDATA_WIDTH];
    endfunction

endpackage

// File: rtl/aes_axis_tx_if.sv
// Output-FIFO read port plus AXI-Stream master bus of the AES transmitter.
interface aes_axis_tx_if;
    import aes_axis_tx_pkg::*;

    logic                            out_fifo_empty;
    logic                            out_fifo_read_tvalid;
    logic                            out_fifo_read_tready;
    logic [0:FIFO_DATA_WIDTH-1]      out_fifo_data;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
    logic [STRB_WIDTH-1:0]           m_axis_tstrb;
    logic                            m_axis_tvalid;
    logic                            m_axis_tready;
    logic                            m_axis_tlast;

    modport master (
        input  out_fifo_empty, out_fifo_read_tvalid, out_fifo_data, m_axis_tready,
        output out_fifo_read_tready, m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output out_fifo_empty, out_fifo_read_tvalid, out_fifo_data, m_axis_tready,
        input  out_fifo_read_tready, m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/aes_axis_tx.sv
// Drains 128-bit AES result blocks from the output FIFO and sends them as four
// 32-bit AXI-Stream beats each, flagging TLAST on the final beat of a message.
//
//  state  | meaning
//  IDLE   | read strobe high, waiting for a block from the FIFO
//  SEND   | streaming beats 0..BEATS-2 of the held block
//  DECIDE | tvalid low until the final beat's TLAST value is known
//  LAST   | streaming the final beat with the resolved TLAST
module aes_axis_tx
    import aes_axis_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 processing_done,
    aes_axis_tx_if.master        axis,
    output logic                 tx_done,
    output logic [CNT_WIDTH-1:0] blocks_sent
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_SEND_IDX = BEAT_CNT_WIDTH'(BEATS - 2);

    tx_state_e                       state_q, state_d;
    logic [0:FIFO_DATA_WIDTH-1]      blk_q, blk_d;
    logic [BEAT_CNT_WIDTH-1:0]       beat_cnt_q, beat_cnt_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [STRB_WIDTH-1:0]           tstrb_q, tstrb_d;
    logic                            tvalid_q, tvalid_d;
    logic                            tlast_q, tlast_d;
    logic                            rd_rdy_q, rd_rdy_d;
    logic                            tx_done_q, tx_done_d;
    logic [CNT_WIDTH-1:0]            blocks_sent_q, blocks_sent_d;
    logic                            fifo_hs;
    logic                            beat_hs;

    assign fifo_hs = rd_rdy_q && axis.out_fifo_read_tvalid;
    assign beat_hs = tvalid_q && axis.m_axis_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            blk_q         <= '0;
            beat_cnt_q    <= '0;
            tdata_q       <= '0;
            tstrb_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            rd_rdy_q      <= 1'b0;
            tx_done_q     <= 1'b0;
            blocks_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            beat_cnt_q    <= beat_cnt_d;
            tdata_q       <= tdata_d;
            tstrb_q       <= tstrb_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            rd_rdy_q      <= rd_rdy_d;
            tx_done_q     <= tx_done_d;
            blocks_sent_q <= blocks_sent_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        beat_cnt_d    = beat_cnt_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tx_done_d     = 1'b0;
        blocks_sent_d = blocks_sent_q;

        // The count stays visible during the tx_done cycle, then restarts for the next message.
        if (tx_done_q) begin
            blocks_sent_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fifo_hs) begin
                    blk_d      = axis.out_fifo_data;
                    beat_cnt_d = '0;
                    tdata_d    = blk_word(axis.out_fifo_data, '0);
                    tvalid_d   = 1'b1;
                    tlast_d    = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    tdata_d    = blk_word(blk_q, beat_cnt_q + 1'b1);
                    if (beat_cnt_q == LAST_SEND_IDX) begin
                        tvalid_d = 1'b0;
                        state_d  = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                // Pending FIFO data means the message continues, even if done is already high.
                if (axis.out_fifo_read_tvalid) begin
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    state_d  = ST_LAST;
                end else if (processing_done && axis.out_fifo_empty) begin
                    tlast_d  = 1'b1;
                    tvalid_d = 1'b1;
                    state_d  = ST_LAST;
                end
            end
            ST_LAST: begin
                if (beat_hs) begin
                    tvalid_d  = 1'b0;
                    tlast_d   = 1'b0;
                    tx_done_d = tlast_q;
                    if (blocks_sent_q != '1) begin
                        blocks_sent_d = blocks_sent_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_rdy_d = (state_d == ST_IDLE);
    assign tstrb_d  = {STRB_WIDTH{tvalid_d}};

    assign axis.out_fifo_read_tready = rd_rdy_q;
    assign axis.m_axis_tdata         = tdata_q;
    assign axis.m_axis_tstrb         = tstrb_q;
    assign axis.m_axis_tvalid        = tvalid_q;
    assign axis.m_axis_tlast         = tlast_q;
    assign tx_done                   = tx_done_q;
    assign blocks_sent               = blocks_sent_q;

endmodule
